// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if: valid/ready stream leaving the read-side FIFO adapter.
// The adapter drives the master side; the downstream consumer takes the slave side.
interface fifo_rd_stream_if #(
    parameter int DATA_WIDTH = 4
);
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;

    modport master (
        output m_valid,
        output m_data,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        output m_ready
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side adapter for the async FIFO.
// Issues FIFO reads only when a skid slot is guaranteed for the returning word,
// so the RAM's fixed read latency never needs backpressure and m_ready has no
// combinational path to fifo_rd_en. Words leave in read order at up to one per cycle.
module fifo_rd_stream #(
    parameter int  DATA_WIDTH = 4,
    parameter int  RD_LATENCY = 1,
    localparam int BUF_DEPTH  = RD_LATENCY + 2,
    localparam int CNT_WIDTH  = $clog2(BUF_DEPTH + 1)
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  flush,
    fifo_rd_stream_if.master      m,
    output logic [CNT_WIDTH-1:0]  buf_level
);
    localparam int PTR_WIDTH = $clog2(BUF_DEPTH);
    // One extra bit so occ + inflight can never wrap before the compare.
    localparam int SUM_WIDTH = CNT_WIDTH + 1;
    localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(BUF_DEPTH - 1);

    logic [CNT_WIDTH-1:0]  occ_reg;
    logic [CNT_WIDTH-1:0]  occ_next;
    logic [PTR_WIDTH-1:0]  head_reg;
    logic [PTR_WIDTH-1:0]  head_next;
    logic [PTR_WIDTH-1:0]  tail_reg;
    logic [PTR_WIDTH-1:0]  tail_next;
    logic [RD_LATENCY-1:0] infl_reg;
    logic [RD_LATENCY-1:0] infl_next;
    logic [SUM_WIDTH-1:0]  inflight;
    logic [SUM_WIDTH-1:0]  committed;
    logic                  valid;
    logic                  capture;
    logic                  pop;
    logic [DATA_WIDTH-1:0] entry_data [BUF_DEPTH];

    // Count reads already issued whose data has not yet arrived.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + SUM_WIDTH'(infl_reg[i]);
        end
    end

    // Every word in the buffer or in flight owns a slot; issue only when one is free.
    assign committed  = SUM_WIDTH'(occ_reg) + inflight;
    assign fifo_rd_en = ~fifo_empty & ~flush & rd_rst_n & (committed < SUM_WIDTH'(BUF_DEPTH));

    assign valid     = (occ_reg != '0);
    assign pop       = valid & m.m_ready;
    // The oldest in-flight read lands this cycle; a flush discards it.
    assign capture   = infl_reg[RD_LATENCY-1] & ~flush;

    assign m.m_valid = valid;
    assign m.m_data  = entry_data[head_reg];
    assign buf_level = occ_reg;

    // Shift the in-flight marker pipe: new reads enter at bit 0, exit at the top bit.
    always_comb begin
        infl_next    = '0;
        infl_next[0] = fifo_rd_en;
        for (int i = 1; i < RD_LATENCY; i++) begin
            infl_next[i] = infl_reg[i-1];
        end
    end

    // Pointer and occupancy update; capture and pop in one cycle move both pointers.
    always_comb begin
        head_next = head_reg;
        tail_next = tail_reg;
        occ_next  = occ_reg;
        if (pop) begin
            head_next = (head_reg == LAST_PTR) ? '0 : head_reg + PTR_WIDTH'(1);
        end
        if (capture) begin
            tail_next = (tail_reg == LAST_PTR) ? '0 : tail_reg + PTR_WIDTH'(1);
        end
        case ({capture, pop})
            2'b10:   occ_next = occ_reg + CNT_WIDTH'(1);
            2'b01:   occ_next = occ_reg - CNT_WIDTH'(1);
            default: occ_next = occ_reg;
        endcase
    end

    // Control state register; reset and flush both empty the buffer and drop in-flight reads.
    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n || flush) begin
            occ_reg  <= '0;
            head_reg <= '0;
            tail_reg <= '0;
            infl_reg <= '0;
        end else begin
            occ_reg  <= occ_next;
            head_reg <= head_next;
            tail_reg <= tail_next;
            infl_reg <= infl_next;
        end
    end

    // Skid storage: one register per slot so the head entry is readable in the same cycle.
    for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
        logic [DATA_WIDTH-1:0] data_reg;

        // Write the returning word into this slot when the tail points at it; only reset clears data.
        always_ff @(posedge rd_clk) begin
            if (!rd_rst_n) begin
                data_reg <= '0;
            end else if (capture && (tail_reg == PTR_WIDTH'(gi))) begin
                data_reg <= fifo_rd_data;
            end
        end

        assign entry_data[gi] = data_reg;
    end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: runs identical traffic into a RD_LATENCY=1 and a RD_LATENCY=3
// instance. Each has its own FIFO/RAM model; a scoreboard of words read (tagged with
// their read edge) predicts level, valid and data every cycle.
module tb_fifo_rd_stream;
    localparam int DW = 4;

    logic clk      = 1'b0;
    logic rd_rst_n = 1'b0;
    logic flush    = 1'b0;
    logic m_ready  = 1'b0;

    logic          fifo_empty   [2];
    logic          fifo_rd_en   [2];
    logic [DW-1:0] fifo_rd_data [2];
    logic [1:0]    level0;
    logic [2:0]    level1;
    logic          mv  [2];
    logic [DW-1:0] md  [2];
    logic [3:0]    lvl [2];

    fifo_rd_stream_if #(.DATA_WIDTH(DW)) s0 ();
    fifo_rd_stream_if #(.DATA_WIDTH(DW)) s1 ();

    assign s0.m_ready = m_ready;
    assign s1.m_ready = m_ready;
    assign mv[0]  = s0.m_valid;
    assign mv[1]  = s1.m_valid;
    assign md[0]  = s0.m_data;
    assign md[1]  = s1.m_data;
    assign lvl[0] = {2'b00, level0};
    assign lvl[1] = {1'b0, level1};

    always #5 clk = ~clk;

    fifo_rd_stream #(.DATA_WIDTH(DW), .RD_LATENCY(1)) dut0 (
        .rd_clk       (clk),
        .rd_rst_n     (rd_rst_n),
        .fifo_empty   (fifo_empty[0]),
        .fifo_rd_en   (fifo_rd_en[0]),
        .fifo_rd_data (fifo_rd_data[0]),
        .flush        (flush),
        .m            (s0),
        .buf_level    (level0)
    );

    fifo_rd_stream #(.DATA_WIDTH(DW), .RD_LATENCY(3)) dut1 (
        .rd_clk       (clk),
        .rd_rst_n     (rd_rst_n),
        .fifo_empty   (fifo_empty[1]),
        .fifo_rd_en   (fifo_rd_en[1]),
        .fifo_rd_data (fifo_rd_data[1]),
        .flush        (flush),
        .m            (s1),
        .buf_level    (level1)
    );

    // FIFO contents, RAM read pipe, and scoreboard of words read but not yet delivered.
    logic [DW-1:0] fmem     [2][512];
    int            fwr      [2];
    int            frd      [2];
    logic [DW-1:0] dpipe    [2][4];
    logic [DW-1:0] exp_data [2][2048];
    int            exp_edge [2][2048];
    int            eh       [2];
    int            et       [2];
    int            pops     [2];
    int            reads    [2];
    int            edge_cnt;
    int            tests;
    int            fails;
    logic [DW-1:0] next_word;

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // Words whose data has had RD_LATENCY edges to arrive are in the buffer.
    function automatic int exp_level(input int d);
        int n;
        n = 0;
        for (int i = eh[d]; i < et[d]; i++) begin
            if (exp_edge[d][i % 2048] + lat_of(d) <= edge_cnt) n++;
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic refresh_empty();
        for (int d = 0; d < 2; d++) fifo_empty[d] = (fwr[d] == frd[d]);
    endtask

    task automatic push_seq(input int n);
        for (int i = 0; i < n; i++) begin
            for (int d = 0; d < 2; d++) begin
                fmem[d][fwr[d] % 512] = next_word;
                fwr[d]++;
            end
            next_word = next_word + DW'(1);
        end
        refresh_empty();
    endtask

    // One clock: check the issue decision, advance the models, then check outputs.
    task automatic step();
        logic rd_s  [2];
        logic pop_s [2];
        int   pre   [2];
        logic fl_s;
        logic rs_s;
        int   lv;
        @(negedge clk);
        fl_s = flush;
        rs_s = !rd_rst_n;
        for (int d = 0; d < 2; d++) begin
            rd_s[d]  = fifo_rd_en[d];
            pop_s[d] = mv[d] & m_ready;
            pre[d]   = exp_level(d);
            chk($sformatf("rd_en%0d", d), 8'(fifo_rd_en[d]),
                8'(!fifo_empty[d] && !fl_s && !rs_s && ((et[d] - eh[d]) < lat_of(d) + 2)));
        end
        @(posedge clk);
        #1;
        edge_cnt++;
        for (int d = 0; d < 2; d++) begin
            for (int k = 3; k > 0; k--) dpipe[d][k] = dpipe[d][k-1];
            if (rd_s[d] === 1'b1) dpipe[d][0] = fmem[d][frd[d] % 512];
            else                  dpipe[d][0] = DW'($urandom);
            if (fl_s || rs_s) begin
                eh[d] = et[d];
            end else if (pop_s[d] === 1'b1 && pre[d] > 0) begin
                eh[d]++;
                pops[d]++;
            end
            if (rd_s[d] === 1'b1) begin
                exp_data[d][et[d] % 2048] = fmem[d][frd[d] % 512];
                exp_edge[d][et[d] % 2048] = edge_cnt;
                et[d]++;
                frd[d]++;
                reads[d]++;
            end
            fifo_rd_data[d] = dpipe[d][lat_of(d)-1];
        end
        refresh_empty();
        #1;
        for (int d = 0; d < 2; d++) begin
            lv = exp_level(d);
            chk($sformatf("level%0d", d), 8'(lvl[d]), 8'(lv));
            chk($sformatf("valid%0d", d), 8'(mv[d]), 8'(lv != 0));
            chk($sformatf("occ_bound%0d", d), 8'(lvl[d] <= 4'(lat_of(d) + 2)), 8'd1);
            if (lv > 0) chk($sformatf("data%0d", d), 8'(md[d]), 8'(exp_data[d][eh[d] % 2048]));
            if (rs_s)   chk($sformatf("rst_data%0d", d), 8'(md[d]), 8'd0);
        end
    endtask

    initial begin
        int first [2];
        int last  [2];
        int vcnt  [2];
        int rbase [2];
        int pbase [2];
        logic [DW-1:0] held;
        logic [DW-1:0] w;

        tests = 0;
        fails = 0;
        edge_cnt = 0;
        next_word = DW'(1);
        for (int d = 0; d < 2; d++) begin
            fwr[d] = 0; frd[d] = 0; eh[d] = 0; et[d] = 0; pops[d] = 0; reads[d] = 0;
            for (int k = 0; k < 4; k++) dpipe[d][k] = '0;
            fifo_rd_data[d] = '0;
        end

        // Reset with a non-empty FIFO holding 0x1..0xA: no reads, nothing valid.
        push_seq(10);
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("rst_rd_en0", 8'(fifo_rd_en[0]), 8'd0);

        // Release reset and stream all ten words with m_ready high.
        rd_rst_n = 1'b1;
        #1;
        chk("first_rd_en0", 8'(fifo_rd_en[0]), 8'd1);
        for (int d = 0; d < 2; d++) begin
            first[d] = -1; last[d] = -1; vcnt[d] = 0; rbase[d] = reads[d];
        end
        for (int k = 0; k < 16; k++) begin
            for (int d = 0; d < 2; d++) begin
                if (mv[d] === 1'b1) begin
                    if (first[d] < 0) first[d] = k;
                    last[d] = k;
                    vcnt[d]++;
                end
            end
            step();
        end
        chk("first_valid0", 8'(first[0]), 8'd2);
        chk("first_valid1", 8'(first[1]), 8'd4);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("valid_cycles%0d", d), 8'(vcnt[d]), 8'd10);
            chk($sformatf("valid_span%0d", d), 8'(last[d] - first[d] + 1), 8'd10);
            chk($sformatf("reads%0d", d), 8'(reads[d] - rbase[d]), 8'd10);
            chk($sformatf("rd_en_drop%0d", d), 8'(fifo_rd_en[d]), 8'd0);
        end

        // Consumer stalled with eight words queued: the buffer fills and holds.
        m_ready = 1'b0;
        for (int d = 0; d < 2; d++) rbase[d] = reads[d];
        w = next_word;
        push_seq(8);
        for (int i = 0; i < 8; i++) step();
        chk("stall_reads0", 8'(reads[0] - rbase[0]), 8'd3);
        chk("stall_reads1", 8'(reads[1] - rbase[1]), 8'd5);
        chk("stall_level0", 8'(lvl[0]), 8'd3);
        chk("stall_level1", 8'(lvl[1]), 8'd5);
        chk("stall_head0", 8'(md[0]), 8'(w));
        held = md[0];
        step();
        step();
        chk("stall_hold0", 8'(md[0]), 8'(held));
        chk("stall_hold_valid0", 8'(mv[0]), 8'd1);
        m_ready = 1'b1;
        for (int d = 0; d < 2; d++) pbase[d] = pops[d];
        for (int i = 0; i < 16; i++) step();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("stall_delivered%0d", d), 8'(pops[d] - pbase[d]), 8'd8);
            chk($sformatf("stall_drained%0d", d), 8'(lvl[d]), 8'd0);
        end

        // A single word: FIFO goes empty right after its read; exactly one read and one delivery.
        for (int d = 0; d < 2; d++) begin
            rbase[d] = reads[d]; pbase[d] = pops[d];
        end
        push_seq(1);
        for (int i = 0; i < 6; i++) step();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("single_reads%0d", d), 8'(reads[d] - rbase[d]), 8'd1);
            chk($sformatf("single_pops%0d", d), 8'(pops[d] - pbase[d]), 8'd1);
        end

        // Flush with two buffered words and one in flight on the latency-1 instance.
        m_ready = 1'b0;
        w = next_word;
        push_seq(5);
        for (int i = 0; i < 3; i++) step();
        chk("pre_flush_level0", 8'(lvl[0]), 8'd2);
        chk("pre_flush_reads0", 8'(reads[0] - rbase[0]), 8'd4);
        flush = 1'b1;
        #1;
        chk("flush_rd_en0", 8'(fifo_rd_en[0]), 8'd0);
        step();
        flush = 1'b0;
        #1;
        chk("flush_valid0", 8'(mv[0]), 8'd0);
        chk("flush_level0", 8'(lvl[0]), 8'd0);
        chk("resume_rd_en0", 8'(fifo_rd_en[0]), 8'd1);
        m_ready = 1'b1;
        step();
        step();
        chk("post_flush_valid0", 8'(mv[0]), 8'd1);
        chk("post_flush_data0", 8'(md[0]), 8'(w + DW'(3)));
        for (int i = 0; i < 12; i++) step();

        // Reset while words are waiting on a stalled consumer.
        m_ready = 1'b0;
        push_seq(4);
        for (int i = 0; i < 6; i++) step();
        chk("pre_rst_valid0", 8'(mv[0]), 8'd1);
        chk("pre_rst_valid1", 8'(mv[1]), 8'd1);
        rd_rst_n = 1'b0;
        step();
        rd_rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("mid_rst_valid%0d", d), 8'(mv[d]), 8'd0);
            chk($sformatf("mid_rst_data%0d", d), 8'(md[d]), 8'd0);
            chk($sformatf("mid_rst_level%0d", d), 8'(lvl[d]), 8'd0);
        end

        // Random traffic: random ready, pushes, occasional flush and reset.
        for (int i = 0; i < 500; i++) begin
            m_ready  = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 49) == 0);
            rd_rst_n = ($urandom_range(0, 149) != 0);
            if ($urandom_range(0, 2) == 0) begin
                next_word = DW'($urandom);
                push_seq(1);
            end
            step();
        end
        flush    = 1'b0;
        rd_rst_n = 1'b1;
        m_ready  = 1'b1;
        for (int i = 0; i < 20; i++) step();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("final_level%0d", d), 8'(lvl[d]), 8'd0);
            chk($sformatf("final_valid%0d", d), 8'(mv[d]), 8'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
Read-side adapter that sits directly downstream of the async FIFO, in the read clock domain. It drives the FIFO's rd_en and absorbs the RAM's fixed read latency into a small skid buffer. It then presents the data as a valid/ready stream with full throughput and no combinational path from m_ready to fifo_rd_en. It also provides a synchronous flush for the read-side consumer.

Parameters:
DATA_WIDTH, 4, width of FIFO read data and m_data.
RD_LATENCY, 1, cycles from fifo_rd_en to fifo_rd_data valid; legal range 1..4.
BUF_DEPTH (localparam), RD_LATENCY+2, number of skid buffer entries.
CNT_WIDTH (localparam), $clog2(BUF_DEPTH+1), width of the occupancy count.

Ports:
rd_clk  input  1  the single clock; all logic on its rising edge.
rd_rst_n  input  1  synchronous, active-low reset, sampled on rd_clk.
fifo_empty  input  1  FIFO empty flag, in the rd_clk domain.
fifo_rd_en  output  1  read request to the FIFO.
fifo_rd_data  input  DATA_WIDTH  FIFO read data, valid RD_LATENCY cycles after fifo_rd_en.
flush  input  1  synchronous clear of the buffer and of any in-flight reads.
m_valid  output  1  the stream word is valid.
m_ready  input  1  the consumer accepts the word.
m_data  output  DATA_WIDTH  stream data, equal to the head buffer entry.
buf_level  output  CNT_WIDTH  number of words currently held in the buffer.

Behaviour:
- Reset: clock is rd_clk; reset is rd_rst_n, synchronous, active-low. While rd_rst_n=0:
  - occupancy=0, in-flight pipe=0, read/write pointers=0.
  - m_valid=0, m_data=0, buf_level=0, fifo_rd_en=0.
- State:
  - BUF_DEPTH-entry circular buffer with head/tail pointers that wrap from BUF_DEPTH-1 to 0.
  - occ register, 0..BUF_DEPTH.
  - RD_LATENCY-bit shift register infl_pipe; inflight = popcount(infl_pipe).
- Read issue:
  - fifo_rd_en = ~fifo_empty & ~flush & rd_rst_n & (occ + inflight < BUF_DEPTH).
  - It depends only on registered state, fifo_empty and flush, never on m_ready.
- In-flight pipe:
  - Each cycle, infl_pipe shifts and its entry bit = fifo_rd_en.
  - When the exit bit is 1, fifo_rd_data is written at tail and tail advances.
- Latency: a word read at cycle t is captured at the end of cycle t+RD_LATENCY. m_valid=1 for it at cycle t+RD_LATENCY+1 at the earliest.
- Output:
  - m_valid = (occ != 0).
  - m_data = mem[head].
  - A pop occurs when m_valid & m_ready; head then advances.
  - m_data and m_valid must hold stable while m_valid=1 and m_ready=0.
- Occupancy:
  - occ_next = occ + capture − pop.
  - Simultaneous capture and pop leave occ unchanged, and both pointers move.
  - buf_level = occ.
- Overflow impossible: the issue rule guarantees occ + inflight ≤ BUF_DEPTH, so a capture is never dropped. The bench asserts occ ≤ BUF_DEPTH.
- Throughput: with m_ready held at 1 and the FIFO non-empty, one word per cycle after fill.
- fifo_empty rises while reads are in flight: issue stops immediately, in-flight words are still captured, and no further rd_en is issued.
- Flush:
  - At the next edge: occ=0, infl_pipe=0, head=tail=0, m_valid=0.
  - Words in flight are discarded, i.e. lost from the FIFO by design.
  - While flush=1: fifo_rd_en=0 and no capture occurs.
  - Flush has priority over pop and capture in the same cycle.
- Reset mid-operation: same effect as flush, plus m_data=0. Reset has priority over flush.
- Ordering: words leave in exactly the order they were read from the FIFO.

Test Plan:
1. Reset with fifo_empty=0 → fifo_rd_en=0, m_valid=0, buf_level=0. First fifo_rd_en in the cycle after rd_rst_n rises; first m_valid 2 cycles later (RD_LATENCY=1).
2. FIFO preloaded with 0x1..0xA, m_ready=1 → m_data sequence 0x1..0xA in order. After the first word, m_valid stays 1 for 10 consecutive cycles. fifo_rd_en drops after the 10th read (fifo_empty=1).
3. m_ready=0 with the FIFO holding 8 words → exactly 3 reads issued, buf_level=3, m_data=first word held stable. After m_ready rises, all 8 words are delivered in order.
4. fifo_empty asserts the cycle after a single rd_en → the in-flight word is still delivered and no extra fifo_rd_en occurs.
5. flush pulse with buf_level=2 and 1 word in flight → next cycle m_valid=0, buf_level=0. The in-flight word never appears. Reads resume the cycle after flush drops.
6. rd_rst_n=0 while m_valid=1, m_ready=0 → next cycle m_valid=0, m_data=0, buf_level=0. The same traffic is rerun with RD_LATENCY=3 (BUF_DEPTH=5): full throughput and order preserved.
